// File: rtl/mem_bus_interface.sv
// Memory-side datapath stage: MAR/MDR registers loaded from the bus, plus a req/ack
// transaction FSM with timeout that reads into or writes from MDR.
module mem_bus_interface #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       BusMuxInMDR,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CntW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   mar_q;
  logic [31:0]         mdr_q;
  logic [CntW-1:0]     cnt_q;
  logic                done_q;
  logic                err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        StIdle: begin
          if (MARin) mar_q <= BusMuxOut[ADDR_W-1:0];
          if (MDRin) mdr_q <= BusMuxOut;
          cnt_q <= '0;
          // Read has priority when both commands arrive together.
          if (Read) begin
            state_q <= StRd;
          end else if (Write) begin
            state_q <= StWr;
          end
        end
        StRd, StWr: begin
          // Ack wins over a timeout landing on the same edge.
          if (mem_ack) begin
            if (state_q == StRd) mdr_q <= mem_rdata;
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q <= StIdle;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request lines decode straight from the state flop so reset drops them at once.
  assign mem_req     = (state_q != StIdle);
  assign mem_we      = (state_q == StWr);
  assign busy        = (state_q != StIdle);
  assign mem_addr    = mar_q;
  assign mem_wdata   = mdr_q;
  assign BusMuxInMDR = mdr_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mem_bus_interface.sv
// Directed self-checking bench for mem_bus_interface: bus loads, read/write
// handshakes, timeout, ignored inputs and reset during a transaction.
module tb_mem_bus_interface;

  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       BusMuxOut;
  logic              MARin, MDRin, Read, Write;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, BusMuxInMDR;
  logic              mem_ack, busy, done, err;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_interface #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .BusMuxOut   (BusMuxOut),
    .MARin       (MARin),
    .MDRin       (MDRin),
    .Read        (Read),
    .Write       (Write),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .BusMuxInMDR (BusMuxInMDR),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [31:0] v, input bit mar, input bit mdr);
    BusMuxOut = v;
    MARin = mar;
    MDRin = mdr;
    @(negedge clk);
    MARin = 1'b0;
    MDRin = 1'b0;
  endtask

  // Issue a command at a negedge and serve it; ack_at = cycle of mem_req to ack on (0 = never).
  task automatic run_txn(input bit rd, input bit wr, input int ack_at, input logic [31:0] rdata,
                         input bit poke, output int req_cycles, output bit we_seen,
                         output bit busy_bad, output bit done_now, output bit err_now,
                         output bit pulse_next);
    Read = rd;
    Write = wr;
    @(negedge clk);
    Read = 1'b0;
    Write = 1'b0;
    req_cycles = 0;
    we_seen = 1'b0;
    busy_bad = 1'b0;
    for (int c = 1; c <= 40 && mem_req; c++) begin
      req_cycles++;
      we_seen  |= mem_we;
      busy_bad |= (busy !== 1'b1) | done | err;
      mem_ack   = (c == ack_at);
      mem_rdata = rdata;
      if (poke && c == 1) begin
        BusMuxOut = 32'hFFFF_FFFF;
        MARin = 1'b1;
        MDRin = 1'b1;
        Read  = 1'b1;
        Write = 1'b1;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      MARin = 1'b0;
      MDRin = 1'b0;
      Read  = 1'b0;
      Write = 1'b0;
    end
    done_now = done;
    err_now  = err;
    @(negedge clk);
    pulse_next = done | err;
  endtask

  int req;
  bit we_s, bbad, d_now, e_now, p_next;

  initial begin
    reset = 1'b1;
    BusMuxOut = '0;
    MARin = 0; MDRin = 0; Read = 0; Write = 0;
    mem_ack = 0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_req",  32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({done, err, mem_we}), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_mdr",  BusMuxInMDR, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    load(32'h0000_01A5, 1, 0);
    check("load_mar", 32'(mem_addr), 32'h1A5);
    load(32'hDEAD_BEEF, 0, 1);
    check("load_mdr", BusMuxInMDR, 32'hDEAD_BEEF);
    check("load_wdata", mem_wdata, 32'hDEAD_BEEF);

    // Read, ack on 3rd request cycle
    load(32'h0000_0010, 1, 0);
    run_txn(1, 0, 3, 32'h1234_5678, 0, req, we_s, bbad, d_now, e_now, p_next);
    check("rd_req_cycles", 32'(req), 32'd3);
    check("rd_we", 32'(we_s), 32'd0);
    check("rd_busy", 32'(bbad), 32'd0);
    check("rd_done", 32'({d_now, e_now}), 32'b10);
    check("rd_pulse_once", 32'(p_next), 32'd0);
    check("rd_mdr", BusMuxInMDR, 32'h1234_5678);
    check("rd_addr", 32'(mem_addr), 32'h010);

    // Write, immediate ack; rdata must not be captured
    load(32'hCAFE_F00D, 0, 1);
    run_txn(0, 1, 1, 32'h0BAD_0BAD, 0, req, we_s, bbad, d_now, e_now, p_next);
    check("wr_req_cycles", 32'(req), 32'd1);
    check("wr_we", 32'(we_s), 32'd1);
    check("wr_done", 32'({d_now, e_now}), 32'b10);
    check("wr_pulse_once", 32'(p_next), 32'd0);
    check("wr_mdr", mem_wdata, 32'hCAFE_F00D);

    // Timeout
    load(32'h5555_5555, 0, 1);
    run_txn(1, 0, 0, 32'hAAAA_AAAA, 0, req, we_s, bbad, d_now, e_now, p_next);
    check("to_req_cycles", 32'(req), 32'd15);
    check("to_err", 32'({d_now, e_now}), 32'b01);
    check("to_pulse_once", 32'(p_next), 32'd0);
    check("to_mdr", BusMuxInMDR, 32'h5555_5555);

    // Ack on the last allowed cycle wins over timeout
    run_txn(1, 0, 15, 32'h0F0F_1234, 0, req, we_s, bbad, d_now, e_now, p_next);
    check("late_req_cycles", 32'(req), 32'd15);
    check("late_done", 32'({d_now, e_now}), 32'b10);
    check("late_mdr", BusMuxInMDR, 32'h0F0F_1234);

    // Read & Write together: read only
    run_txn(1, 1, 2, 32'h7777_8888, 0, req, we_s, bbad, d_now, e_now, p_next);
    check("rw_we", 32'(we_s), 32'd0);
    check("rw_mdr", BusMuxInMDR, 32'h7777_8888);

    // Bus loads ignored while busy (let it time out so MDR stays put)
    load(32'h0000_0033, 1, 1);
    run_txn(1, 0, 0, 32'h0, 1, req, we_s, bbad, d_now, e_now, p_next);
    check("ign_req_cycles", 32'(req), 32'd15);
    check("ign_mar", 32'(mem_addr), 32'h033);
    check("ign_mdr", BusMuxInMDR, 32'h0000_0033);

    // Ack while idle
    mem_ack = 1'b1;
    mem_rdata = 32'h9999_9999;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_flags", 32'({mem_req, busy, done, err}), 32'd0);
    check("idle_ack_mdr", BusMuxInMDR, 32'h0000_0033);

    // Reset on the 2nd request cycle
    Read = 1'b1;
    @(negedge clk);
    Read = 1'b0;
    @(negedge clk);
    check("mid_req_before", 32'(mem_req), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_req", 32'({mem_req, busy}), 32'd0);
    check("mid_rst_regs", 32'(mem_addr) | BusMuxInMDR, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_flags", 32'({done, err}), 32'd0);

    load(32'h0000_0155, 1, 0);
    run_txn(1, 0, 2, 32'hA5A5_5A5A, 0, req, we_s, bbad, d_now, e_now, p_next);
    check("post_req_cycles", 32'(req), 32'd2);
    check("post_done", 32'({d_now, e_now}), 32'b10);
    check("post_mdr", BusMuxInMDR, 32'hA5A5_5A5A);
    check("post_addr", 32'(mem_addr), 32'h155);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
